inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 130 +++++++++++++
 tb/tb_inst_fetch.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch
//  Purpose  : Instruction-fetch stage. It issues one word-aligned read at a
//             time to instruction memory and registers the returned word into
//             the IF/ID register. When decode stalls while a word is arriving,
//             a one-entry skid buffer absorbs the word so that it is not lost.
//             Redirects from branches or jumps restart fetch at a new address
//             and flush anything in flight.
//
//  Ports    : clk, rst          - clock and synchronous active-high reset
//             imem_req/addr     - read request and word-aligned address
//             imem_ack/rdata    - read completion and returned word
//             stall             - decode cannot accept a new instruction
//             redirect/_pc      - restart fetch at redirect_pc
//             if_valid/instr/pc4- IF/ID register contents
//             OP, funct         - opcode and function fields of if_instr
//
//  Revision : 1.0  initial release
// ============================================================================
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4,
    output logic [5:0]  OP,
    output logic [5:0]  funct
);

    localparam logic [31:0] c_pc_step   = 32'd4;
    localparam logic [31:0] c_word_mask = 32'hFFFF_FFFC;

    // FETCH: a request is outstanding at r_pc.
    // HOLD : the skid buffer holds a word waiting for decode to free up;
    //        no request is issued until it has been handed over.
    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc4;
    logic        r_if_valid;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc4;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_addr;
    logic        w_if_free;

    // Natural 32-bit overflow gives the required wrap from FFFF_FFFC to 0.
    assign w_pc_plus4      = r_pc + c_pc_step;
    assign w_redirect_addr = redirect_pc & c_word_mask;
    // IF/ID may be overwritten when decode is consuming it or it is empty.
    assign w_if_free       = !stall || !r_if_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC;
            r_skid_instr <= 32'd0;
            r_skid_pc4   <= 32'd0;
            r_if_valid   <= 1'b0;
            r_if_instr   <= 32'd0;
            r_if_pc4     <= 32'd0;
        end else if (redirect) begin
            // Any ack in this cycle belongs to the abandoned path and is
            // dropped; the skid entry is discarded by leaving HOLD.
            r_state    <= ST_FETCH;
            r_pc       <= w_redirect_addr;
            r_if_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_pc <= w_pc_plus4;
                        if (w_if_free) begin
                            r_if_instr <= imem_rdata;
                            r_if_pc4   <= w_pc_plus4;
                            r_if_valid <= 1'b1;
                        end else begin
                            // Decode is holding a live word: park this one.
                            r_skid_instr <= imem_rdata;
                            r_skid_pc4   <= w_pc_plus4;
                            r_state      <= ST_HOLD;
                        end
                    end else if (!stall) begin
                        // Current word consumed and nothing new arrived.
                        r_if_valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        r_if_instr <= r_skid_instr;
                        r_if_pc4   <= r_skid_pc4;
                        r_if_valid <= 1'b1;
                        r_state    <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    // The address is the pc register itself, so it cannot move while a
    // request waits for its ack except through a redirect.
    assign imem_req  = (r_state == ST_FETCH);
    assign imem_addr = r_pc;
    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc4    = r_if_pc4;
    assign OP        = r_if_instr[31:26];
    assign funct     = r_if_instr[5:0];

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch
//  Purpose  : Directed self-checking bench for inst_fetch. Accepted fetches
//             push {word, address+4} to a scoreboard; every new instruction
//             appearing in IF/ID pops and compares against it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic [5:0]  OP;
    logic [5:0]  funct;

    int          n_vec;
    int          n_err;
    logic [63:0] sb[$];
    logic [31:0] exp_pc;

    inst_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc4      (if_pc4),
        .OP          (OP),
        .funct       (funct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus. exp_req states whether a request must be
    // outstanding before the edge; an ack during a request (no redirect)
    // is an accepted fetch and is pushed to the scoreboard.
    task automatic step(input logic a, input logic [31:0] d, input logic s,
                        input logic r, input logic [31:0] rp, input logic exp_req);
        logic        pv;
        logic [63:0] e;
        imem_ack    = a;
        imem_rdata  = d;
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, exp_pc);
        pv = if_valid;
        if (r) begin
            exp_pc = rp & 32'hFFFF_FFFC;
        end else if (a && exp_req) begin
            sb.push_back({d, exp_pc + 32'd4});
            exp_pc = exp_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        // A new instruction is present if IF/ID was empty or was consumed.
        if (if_valid && (!pv || !s)) begin
            n_vec++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL sb_underflow: observed instr %h expected none", if_instr);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("if_instr", if_instr, e[63:32]);
                chk("if_pc4", if_pc4, e[31:0]);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; stall = 1'b0;
        redirect = 1'b0; redirect_pc = 32'd0;
        exp_pc = RESET_PC;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_pc4", if_pc4, 32'd0);

        // Streaming at one instruction per cycle: addresses 0, 4, 8.
        step(1'b1, 32'h0230_8020, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("op_add", 32'(OP), 32'h00);
        chk("funct_add", 32'(funct), 32'h20);
        step(1'b1, 32'h0230_8020, 1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b1, 32'h0230_8020, 1'b0, 1'b0, 32'd0, 1'b1);

        // Ack while stalled with a live word: skid, HOLD, IF/ID unchanged.
        step(1'b1, 32'h8C22_0004, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("hold_req", 32'(imem_req), 32'd0);
        chk("hold_instr", if_instr, 32'h0230_8020);
        chk("hold_pc4", if_pc4, 32'h0000_000C);
        step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("skid_op", 32'(OP), 32'h23);
        step(1'b1, 32'h1111_2222, 1'b0, 1'b0, 32'd0, 1'b1);

        // No ack for three cycles: address stable, bubbles.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'hBAD0_0000, 1'b0, 1'b0, 32'd0, 1'b1);
            chk("bubble_valid", 32'(if_valid), 32'd0);
        end
        step(1'b1, 32'h2222_3333, 1'b0, 1'b0, 32'd0, 1'b1);

        // Redirect with coincident ack: ack dropped, address aligned.
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0043, 1'b1);
        chk("redir_valid", 32'(if_valid), 32'd0);
        chk("redir_addr", imem_addr, 32'h0000_0040);
        step(1'b1, 32'h3333_4444, 1'b0, 1'b0, 32'd0, 1'b1);

        // Redirect under stall to the top word, then wrap.
        step(1'b0, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        chk("redir_stall_valid", 32'(if_valid), 32'd0);
        step(1'b1, 32'h4444_5555, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("wrap_pc4", if_pc4, 32'h0000_0000);
        chk("wrap_addr", imem_addr, 32'h0000_0000);

        // Redirect while in HOLD discards the skid entry.
        step(1'b1, 32'h5555_6666, 1'b1, 1'b0, 32'd0, 1'b1);
        void'(sb.pop_back());
        step(1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
        chk("redir_hold_valid", 32'(if_valid), 32'd0);
        step(1'b1, 32'h6666_7777, 1'b0, 1'b0, 32'd0, 1'b1);

        // Reset in HOLD, with redirect/ack/stall also asserted.
        step(1'b1, 32'h7777_8888, 1'b1, 1'b0, 32'd0, 1'b1);
        rst = 1'b1; imem_ack = 1'b1; stall = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h0000_0500;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_pc = RESET_PC;
        chk("rst_hold_valid", 32'(if_valid), 32'd0);
        chk("rst_hold_addr", imem_addr, RESET_PC);
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("rst_hold_nodeliver", 32'(if_valid), 32'd0);
        step(1'b1, 32'h9999_AAAA, 1'b0, 1'b0, 32'd0, 1'b1);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
